// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: decode/execute hazard controller for the 5-stage core.
// Detects load-use hazards with a programmable bubble count, tracks one
// outstanding multi-cycle MDU result, applies taken-branch flushes and
// keeps a saturating count of stalled cycles. Control outputs are
// combinational from registered state plus the current-cycle inputs.
// LOAD_LAT must lie in 1..7 so that LOAD_LAT-1 fits the bubble counter.
module hazard_scoreboard #(
  parameter int REG_W    = 5,
  parameter int LOAD_LAT = 1,
  parameter int PERF_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_ex_memRead,
  input  logic [REG_W-1:0]  id_ex_rd,
  input  logic [REG_W-1:0]  if_id_rs1,
  input  logic [REG_W-1:0]  if_id_rs2,
  input  logic              if_id_uses_rs1,
  input  logic              if_id_uses_rs2,
  input  logic              if_id_is_mdu,
  input  logic              mdu_start,
  input  logic [REG_W-1:0]  mdu_rd,
  input  logic              mdu_done,
  input  logic              ex_branch_taken,
  output logic              stall,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              id_ex_flush,
  output logic              if_id_flush,
  output logic              mdu_busy,
  output logic [PERF_W-1:0] stall_cycles
);

  localparam int LU_W = 3;
  localparam logic [LU_W-1:0] LU_RELOAD = LU_W'(LOAD_LAT - 1);

  logic [LU_W-1:0]  lu_cnt;
  logic [LU_W-1:0]  lu_cnt_next;
  logic [REG_W-1:0] mdu_dst;

  logic hit_ex_rd;
  logic hit_mdu_dst;
  logic lu_new;
  logic lu_hold;
  logic mdu_block;
  logic mdu_raw;
  logic mdu_struct;
  logic hazard;

  // True when the ID instruction actually reads register r (x0 never matches).
  function automatic logic src_hit(
    input logic [REG_W-1:0] r,
    input logic [REG_W-1:0] rs1,
    input logic [REG_W-1:0] rs2,
    input logic             uses1,
    input logic             uses2
  );
    return (r != '0) && ((uses1 && (rs1 == r)) || (uses2 && (rs2 == r)));
  endfunction

  // Hazard detection from registered state and current-cycle inputs.
  always_comb begin
    hit_ex_rd   = src_hit(id_ex_rd, if_id_rs1, if_id_rs2, if_id_uses_rs1, if_id_uses_rs2);
    hit_mdu_dst = src_hit(mdu_dst,  if_id_rs1, if_id_rs2, if_id_uses_rs1, if_id_uses_rs2);
    lu_hold     = (lu_cnt != '0);
    lu_new      = !lu_hold && id_ex_memRead && hit_ex_rd;
    // mdu_done offers a bypass, so the MDU hazards release in the done cycle.
    mdu_block   = mdu_busy && !mdu_done;
    mdu_raw     = mdu_block && hit_mdu_dst;
    mdu_struct  = mdu_block && if_id_is_mdu;
    hazard      = lu_hold || lu_new || mdu_raw || mdu_struct;
  end

  // Pipeline control outputs; reset and taken branches override stalling.
  always_comb begin
    stall       = hazard && !ex_branch_taken && !rst;
    pc_write    = !stall;
    if_id_write = !stall;
    id_ex_flush = rst || stall || ex_branch_taken;
    if_id_flush = rst || ex_branch_taken;
  end

  // Load-use bubble counter next value: first hazard cycle reloads, then count down.
  always_comb begin
    lu_cnt_next = '0;
    if (ex_branch_taken) begin
      lu_cnt_next = '0;
    end else if (lu_hold) begin
      lu_cnt_next = lu_cnt - 1'b1;
    end else if (lu_new) begin
      lu_cnt_next = LU_RELOAD;
    end
  end

  // Load-use bubble counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      lu_cnt <= '0;
    end else begin
      lu_cnt <= lu_cnt_next;
    end
  end

  // MDU scoreboard: a start in the same cycle as a done takes precedence.
  always_ff @(posedge clk) begin
    if (rst) begin
      mdu_busy <= 1'b0;
      mdu_dst  <= '0;
    end else if (mdu_start) begin
      mdu_busy <= 1'b1;
      mdu_dst  <= mdu_rd;
    end else if (mdu_done) begin
      mdu_busy <= 1'b0;
    end
  end

  // Saturating stall-cycle performance counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (stall && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule
